spi_slave_sync: RTL and testbench
=================================

Name: spi_slave_sync

Overview:
SPI responder (slave) that runs entirely on the system clock and receives SCLK, CS_N and MOSI from an external master as asynchronous inputs.
- Oversamples and synchronizes those inputs, then shifts received bits into rx_data.
- Drives MISO from a one-entry transmit holding buffer.
- Mode 0 only (CPOL=0, CPHA=0), MSB first.
- Pairs with the in-house SPI master at board or chip boundaries, where SCLK is not a design clock.

Parameters:
DATA_WIDTH, 8, bits per SPI word; also the width of tx_data and rx_data.
SYNC_STAGES, 2, synchronizer flop depth on sclk, cs_n and mosi; legal values are 2 or more.

Ports:
clk  input  1  system clock; must run at least 4x the SCLK frequency.
rst  input  1  asynchronous reset, active-high.
sclk  input  1  SPI clock from the master, asynchronous to clk.
cs_n  input  1  chip select from the master, active-low, asynchronous.
mosi  input  1  serial data from the master, asynchronous.
miso  output  1  serial data to the master.
tx_data  input  DATA_WIDTH  next word to transmit.
tx_valid  input  1  tx_data is valid.
tx_ready  output  1  holding buffer is empty; tx_data is accepted when tx_valid && tx_ready.
rx_data  output  DATA_WIDTH  last complete received word; held until the next completion.
rx_valid  output  1  single-cycle pulse when rx_data updates.
busy  output  1  high while selected (state ACTIVE).

Behaviour:
- Reset values (asynchronous): miso=0, tx_ready=1, rx_data=0, rx_valid=0, busy=0, state=IDLE, bit_cnt=0, shift registers=0.
  - Synchronizer chains reset to sclk=0, cs_n=1, mosi=0.
- Synchronizers:
  - Each input passes through SYNC_STAGES flops.
  - One further register on synced sclk and cs_n provides edge detection: sclk_rise, sclk_fall, cs_fall, cs_rise, each one cycle wide.
- TX holding buffer:
  - Single entry with a tx_full flag; tx_ready = !tx_full.
  - A word is consumed only at a word-load event.
  - Load and accept in the same cycle cannot collide, because tx_ready=1 implies the buffer is empty.
- Word-load event: loads tx_shift from the buffer if tx_full, otherwise all zeros (underrun); clears tx_full. It occurs on:
  - cs_fall in IDLE;
  - the first sclk_fall after a word completes in ACTIVE.
- State machine:
  - IDLE: miso=0. cs_fall causes a word-load, bit_cnt=0, and a move to ACTIVE.
  - ACTIVE:
    - miso = tx_shift MSB.
    - On sclk_rise: rx_shift shifts left taking synced mosi; bit_cnt increments.
    - On sclk_fall: tx_shift shifts left, zero-filled, unless this is a word-load fall.
    - When bit_cnt reaches DATA_WIDTH on an sclk_rise, the next cycle has rx_data = assembled word and rx_valid=1 for one cycle, and bit_cnt wraps to 0.
    - cs_rise returns the block to IDLE.
- Back-to-back words: CS_N stays low and each completion triggers a reload, with no gap cycles required.
- Abort: cs_rise mid-word (bit_cnt not equal to 0).
  - The partial word is discarded: no rx_valid, rx_data unchanged, bit_cnt cleared.
  - The already-loaded tx word is lost and is not returned to the buffer.
- cs_rise and the final sclk_rise detected in the same cycle: the word completes (rx_valid pulses), then the block goes to IDLE.
- Reset mid-transfer clears everything immediately; the holding buffer is emptied.
- Latency: rx_valid asserts SYNC_STAGES+2 clk cycles after the first clk edge that samples the raw last sclk rising edge high.

Optional Feature:
SPI_SLAVE_MISO_OE_EN
- Defined:
  - Adds output port miso_oe (1 bit, reset 0). miso_oe = busy, so the pad is tri-stated when not selected.
  - miso holds tx_shift MSB regardless of state (don't-care when miso_oe=0).
- Undefined: no miso_oe port; miso is forced to 0 in IDLE as described above.

Test Plan:
- Basic word: tx_data=8'h3C loaded before select; master sends 8'hA5 in mode 0 with clk = 10x sclk.
  -> rx_data=8'hA5 with one rx_valid pulse; miso bits sampled by the master = 0,0,1,1,1,1,0,0 (8'h3C); tx_ready returns to 1 at cs_fall.
- Underrun: no tx_valid; master sends 8'hFF.
  -> miso is 0 for all 8 bits; rx_data=8'hFF.
- Back-to-back: tx 8'h56, then 8'h78 written while the first word shifts; master sends 8'h12, 8'h34 under one CS_N low.
  -> two rx_valid pulses with 8'h12 then 8'h34; master receives 8'h56 then 8'h78.
- Abort: cs_n rises after 4 bits of 8'hC3; new frame sends 8'hF0.
  -> no pulse for the aborted frame; exactly one rx_valid with 8'hF0; rx_data holds 8'hF0.
- Reset mid-word: rst pulsed after 5 bits with tx_full=1.
  -> all outputs at reset values; tx_ready=1; the next full frame 8'h5A is received correctly.
- With SPI_SLAVE_MISO_OE_EN defined: miso_oe is 0 in IDLE, rises within SYNC_STAGES+2 cycles of cs_n falling, and falls the same number of cycles after cs_n rises.

Source files
------------

// File: rtl/spi_slave_sync.sv
// Mode-0 SPI responder that runs on the system clock and oversamples asynchronous SCLK/CS_N/MOSI.
// Optional SPI_SLAVE_MISO_OE_EN adds a miso_oe output for a tri-state pad.
module spi_slave_sync #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
`ifdef SPI_SLAVE_MISO_OE_EN
    output logic                  miso_oe,
`endif
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                  state;
    logic [SYNC_STAGES-1:0]  sclk_sync;
    logic [SYNC_STAGES-1:0]  cs_sync;
    logic [SYNC_STAGES-1:0]  mosi_sync;
    logic                    sclk_d;
    logic                    cs_d;
    logic                    mosi_d;
    logic                    sclk_rise;
    logic                    sclk_fall;
    logic                    cs_fall;
    logic                    cs_rise;
    logic [DATA_WIDTH-1:0]   tx_buf;
    logic                    tx_full;
    logic [DATA_WIDTH-1:0]   tx_shift;
    logic [DATA_WIDTH-1:0]   rx_shift;
    logic [CW-1:0]           bit_cnt;
    logic                    reload_pend;
    logic                    word_load;

    // Edge pulses are registered; mosi_d is captured alongside so it lines up with sclk_rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
            mosi_d    <= 1'b0;
            sclk_rise <= 1'b0;
            sclk_fall <= 1'b0;
            cs_fall   <= 1'b0;
            cs_rise   <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
            cs_d      <= cs_sync[SYNC_STAGES-1];
            mosi_d    <= mosi_sync[SYNC_STAGES-1];
            sclk_rise <= sclk_sync[SYNC_STAGES-1] & ~sclk_d;
            sclk_fall <= ~sclk_sync[SYNC_STAGES-1] & sclk_d;
            cs_fall   <= ~cs_sync[SYNC_STAGES-1] & cs_d;
            cs_rise   <= cs_sync[SYNC_STAGES-1] & ~cs_d;
        end
    end

    assign word_load = ((state == IDLE) && cs_fall) ||
                       ((state == ACTIVE) && sclk_fall && reload_pend);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            tx_buf      <= '0;
            tx_full     <= 1'b0;
            tx_shift    <= '0;
            rx_shift    <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            bit_cnt     <= '0;
            reload_pend <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (bit_cnt == CW'(DATA_WIDTH)) begin
                rx_data  <= rx_shift;
                rx_valid <= 1'b1;
                bit_cnt  <= '0;
            end
            if (word_load) begin
                tx_shift <= tx_full ? tx_buf : '0;
                tx_full  <= 1'b0;
            end
            // Accept after load so an underrun load cannot swallow a same-cycle write.
            if (tx_valid && !tx_full) begin
                tx_buf  <= tx_data;
                tx_full <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        bit_cnt     <= '0;
                        reload_pend <= 1'b0;
                        state       <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (sclk_rise) begin
                        rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_d};
                        bit_cnt  <= bit_cnt + 1'b1;
                        if (bit_cnt == CW'(DATA_WIDTH - 1))
                            reload_pend <= 1'b1;
                    end
                    if (sclk_fall) begin
                        if (reload_pend)
                            reload_pend <= 1'b0;
                        else
                            tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
                    end
                    // A final rise coinciding with deselect still completes the word.
                    if (cs_rise) begin
                        state       <= IDLE;
                        reload_pend <= 1'b0;
                        if (!(sclk_rise && bit_cnt == CW'(DATA_WIDTH - 1)))
                            bit_cnt <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy     = (state == ACTIVE);
    assign tx_ready = ~tx_full;

`ifdef SPI_SLAVE_MISO_OE_EN
    assign miso    = tx_shift[DATA_WIDTH-1];
    assign miso_oe = busy;
`else
    assign miso    = busy & tx_shift[DATA_WIDTH-1];
`endif

endmodule

// File: tb/tb_spi_slave_sync.sv
// Scoreboard bench for spi_slave_sync: directed mode-0 frames, monitors compare rx words and master-received miso words.
module tb_spi_slave_sync;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b0;
    logic       cs_n = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
`ifdef SPI_SLAVE_MISO_OE_EN
    logic       miso_oe;
`endif

    spi_slave_sync #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .sclk     (sclk),
        .cs_n     (cs_n),
        .mosi     (mosi),
        .miso     (miso),
`ifdef SPI_SLAVE_MISO_OE_EN
        .miso_oe  (miso_oe),
`endif
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_rx[$];
    logic [7:0] exp_mi[$];
    logic [7:0] got_mi[$];
    logic       prev_v = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // Monitors: rx words and master-side miso words against the expected queues.
    always @(negedge clk) begin
        if (!rst && rx_valid) begin
            check("rx_pulse_single", {31'd0, prev_v}, 32'd0);
            if (exp_rx.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL rx_unexpected: actual %0h required none", rx_data);
            end else begin
                check("rx_word", {24'd0, rx_data}, {24'd0, exp_rx.pop_front()});
            end
        end
        prev_v = rx_valid;
        if (got_mi.size() > 0) begin
            if (exp_mi.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL miso_unexpected: actual %0h required none", got_mi[0]);
                void'(got_mi.pop_front());
            end else begin
                check("miso_word", {24'd0, got_mi.pop_front()}, {24'd0, exp_mi.pop_front()});
            end
        end
    end

    task automatic push(input logic [7:0] d);
        int k = 0;
        @(negedge clk);
        while (!tx_ready && k < 1000) begin
            @(negedge clk);
            k++;
        end
        if (!tx_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL tx_push_timeout: actual tx_ready=0 required 1");
        end
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Master side: sclk = 10 clk periods, miso sampled on the rising edge.
    task automatic send(input logic [7:0] m, input int nb, output logic [7:0] s);
        s = 8'h00;
        for (int i = 7; i >= 8 - nb; i--) begin
            mosi = m[i];
            #50 sclk = 1'b1;
            s[i] = miso;
            #50 sclk = 1'b0;
        end
    endtask

    task automatic frame(input logic [7:0] m, input logic [7:0] exp_s);
        logic [7:0] s;
        exp_rx.push_back(m);
        exp_mi.push_back(exp_s);
        cs_n = 1'b0;
        #100;
        send(m, 8, s);
        got_mi.push_back(s);
        #100 cs_n = 1'b1;
        #200;
    endtask

    initial begin
        logic [7:0] s0;
        logic [7:0] s1;
        #20;
        check("rst_miso", {31'd0, miso}, 32'd0);
        check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("rst_rx_data", {24'd0, rx_data}, 32'd0);
        check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
`ifdef SPI_SLAVE_MISO_OE_EN
        check("rst_miso_oe", {31'd0, miso_oe}, 32'd0);
`endif
        rst = 1'b0;
        #100;

        // Basic word
        push(8'h3C);
        check("tx_ready_full", {31'd0, tx_ready}, 32'd0);
        #20;
        exp_rx.push_back(8'hA5);
        exp_mi.push_back(8'h3C);
`ifdef SPI_SLAVE_MISO_OE_EN
        check("oe_idle", {31'd0, miso_oe}, 32'd0);
`endif
        cs_n = 1'b0;
        #40;
`ifdef SPI_SLAVE_MISO_OE_EN
        check("oe_rise", {31'd0, miso_oe}, 32'd1);
`endif
        #60;
        check("tx_ready_after_load", {31'd0, tx_ready}, 32'd1);
        check("busy_active", {31'd0, busy}, 32'd1);
        send(8'hA5, 8, s0);
        got_mi.push_back(s0);
        #100 cs_n = 1'b1;
        #40;
`ifdef SPI_SLAVE_MISO_OE_EN
        check("oe_fall", {31'd0, miso_oe}, 32'd0);
`endif
        check("busy_idle", {31'd0, busy}, 32'd0);
        #160;
        check("rx_hold_a5", {24'd0, rx_data}, 32'h0000_00A5);

        // Underrun
        frame(8'hFF, 8'h00);
        check("rx_hold_ff", {24'd0, rx_data}, 32'h0000_00FF);

        // Back-to-back under one select
        push(8'h56);
        #20;
        exp_rx.push_back(8'h12);
        exp_rx.push_back(8'h34);
        exp_mi.push_back(8'h56);
        exp_mi.push_back(8'h78);
        cs_n = 1'b0;
        #100;
        fork
            begin
                send(8'h12, 8, s0);
                got_mi.push_back(s0);
                send(8'h34, 8, s1);
                got_mi.push_back(s1);
            end
            begin
                #300;
                push(8'h78);
            end
        join
        #100 cs_n = 1'b1;
        #200;

        // Abort after 4 bits
        cs_n = 1'b0;
        #100;
        send(8'hC3, 4, s0);
        #100 cs_n = 1'b1;
        #200;
        check("abort_rx_hold", {24'd0, rx_data}, 32'h0000_0034);
        check("abort_idle", {31'd0, busy}, 32'd0);
        frame(8'hF0, 8'h00);
        check("rx_hold_f0", {24'd0, rx_data}, 32'h0000_00F0);

        // Reset mid-word with a full holding buffer
        push(8'h99);
        #20;
        check("tx_ready_full2", {31'd0, tx_ready}, 32'd0);
        cs_n = 1'b0;
        #100;
        send(8'h77, 5, s0);
        #20 rst = 1'b1;
        #20;
        check("rst2_miso", {31'd0, miso}, 32'd0);
        check("rst2_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("rst2_rx_data", {24'd0, rx_data}, 32'd0);
        check("rst2_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst2_busy", {31'd0, busy}, 32'd0);
        #20 rst = 1'b0;
        cs_n = 1'b1;
        #300;
        check("post_rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        frame(8'h5A, 8'h00);
        check("rx_hold_5a", {24'd0, rx_data}, 32'h0000_005A);

        #100;
        check("exp_rx_drained", exp_rx.size(), 32'd0);
        check("exp_miso_drained", exp_mi.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
